tl_ul_master_adapter: RTL and testbench
=======================================

Name: tl_ul_master_adapter

Overview:
Host-side TileLink-UL master adapter that sits directly upstream of tilelink_ul_1M_3S and drives its A-channel inputs. It converts simple host read/write requests into Get/PutFullData/PutPartialData beats and allocates a free source ID per request. It accepts D-channel responses and returns them to the host in arrival order. Responses may arrive out of order across slaves.

Parameters:
TL_ADDR_WIDTH, 64, address width
TL_DATA_WIDTH, 64, data width
TL_STRB_WIDTH, TL_DATA_WIDTH/8, byte-mask width
TL_SOURCE_WIDTH, 3, source ID width; pool size NSRC = 2**TL_SOURCE_WIDTH
TL_SINK_WIDTH, 3, sink ID width
TL_OPCODE_WIDTH, 3, opcode width
TL_PARAM_WIDTH, 3, param width
TL_SIZE_WIDTH, 8, size field width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
req_valid  in  1  host request valid
req_ready  out  1  host request accepted this cycle when high with req_valid
req_write  in  1  1 = write, 0 = read
req_addr  in  TL_ADDR_WIDTH  byte address
req_wdata  in  TL_DATA_WIDTH  write data
req_mask  in  TL_STRB_WIDTH  write byte mask
rsp_valid  out  1  response valid
rsp_ready  in  1  host accepts response
rsp_write  out  1  response belongs to a write
rsp_rdata  out  TL_DATA_WIDTH  read data; 0 for writes
rsp_error  out  1  d_error, or opcode mismatch
rsp_source  out  TL_SOURCE_WIDTH  source ID of the completed request
a_valid, a_opcode, a_param, a_address, a_size, a_mask, a_data, a_source  out  std widths  TL-UL A channel
a_ready  in  1  A-channel ready
d_valid, d_opcode, d_param, d_size, d_data, d_source, d_sink, d_error  in  std widths  TL-UL D channel
d_ready  out  1  D-channel ready
outstanding  out  TL_SOURCE_WIDTH+1  count of in-flight source IDs
unexpected_rsp  out  1  sticky: D beat received for a source that is not in flight

Behaviour:
- Reset (rst=0, async): a_valid=0, rsp_valid=0, all A/rsp payload registers=0, inflight vector=0, outstanding=0, unexpected_rsp=0. d_ready follows its combinational equation, so it is 1 after reset.
- Reset mid-operation discards every in-flight transaction. A post-reset D beat for a pre-reset source sets unexpected_rsp.
- req_ready = (!a_valid || a_ready) && (outstanding < NSRC). Purely combinational; does not depend on req_valid.
- Request accept at cycle N gives a_valid=1 at N+1 (single output register).
- The A payload and a_valid are held stable until a_ready. Back-to-back accepts are allowed when a_ready=1.
- Opcode mapping:
  - Read: GET_A (4) with a_mask all ones.
  - Write with req_mask all ones: PUT_FULL_DATA_A (0).
  - Any other write, including mask 0: PUT_PARTIAL_DATA_A (1).
- a_param=0. a_size=log2(TL_STRB_WIDTH) (3 at default).
- a_address = req_addr with the low log2(TL_STRB_WIDTH) bits forced to 0.
- a_data = req_wdata for writes, 0 for reads.
- Source allocation: lowest-index free bit of the inflight vector. Set inflight[id] and record is_read[id] on accept.
- d_ready = !rsp_valid || rsp_ready (one-entry response register).
- On a D handshake at cycle M with inflight[d_source]=1:
  - Clear inflight[d_source].
  - rsp_valid=1 at M+1 with rsp_source=d_source and rsp_rdata=d_data if the source was a read, else 0.
  - rsp_error = d_error OR (read && d_opcode!=ACCESS_ACK_DATA_D(1)) OR (write && d_opcode!=ACCESS_ACK_D(0)).
- On a D handshake with inflight[d_source]=0: beat dropped, no rsp, unexpected_rsp set until reset.
- Simultaneous allocate and free in the same cycle:
  - Allocation uses the pre-edge free vector, so a freed ID is reusable the next cycle.
  - outstanding = old + alloc - free; when both occur it is unchanged.
- At outstanding=NSRC, req_ready=0 until a response frees an ID.
- d_param, d_size and d_sink are ignored.

Decomposition:
- Shared package tl_ul_pkg holds:
  - A-channel opcode constants: PUT_FULL_DATA_A=0, PUT_PARTIAL_DATA_A=1, GET_A=4.
  - D-channel opcode constants: ACCESS_ACK_D=0, ACCESS_ACK_DATA_D=1.
  - A function log2 of the strobe width.
- One sub-module, tl_source_id_pool: inflight vector, lowest-free priority encoder, alloc/free ports, count output, full flag.

Test Plan:
- After rst=0→1: Write addr 0, data DEADBEEF_CAFEBABE, mask FF → a_opcode=0, a_source=0, a_size=3 one cycle after accept. Drive AccessAck → rsp_valid, rsp_write=1, rsp_error=0, rsp_source=0.
- Read addr 600, then read addr 1200, back-to-back → sources 0 and 1, a_opcode=4, a_mask=FF. Return D for source 1 first, then source 0 → rsp order 1 then 0, correct data each, outstanding 2→1→0.
- Issue 8 reads with no D beats → outstanding=8, req_ready=0. Ack source 5 → req_ready=1 the next cycle; next accept gets a_source=5.
- Write mask 0F at addr 0x203 → a_opcode=1, a_address=0x200, a_mask=0F.
- Hold a_ready=0 for 5 cycles with a request pending → a_valid and payload stable, req_ready=0. Hold rsp_ready=0 → d_ready=0 while rsp_valid=1.
- Read acked with opcode 0 → rsp_error=1. D beat with d_source=7 not in flight → dropped, unexpected_rsp=1 until rst. Reset with 3 outstanding → outstanding=0, a_valid=0 immediately.

Source files
------------

// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL constants for the host-side master adapter and its source-ID pool.
package tl_ul_pkg;

    localparam logic [2:0] PUT_FULL_DATA_A    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL_DATA_A = 3'd1;
    localparam logic [2:0] GET_A              = 3'd4;

    localparam logic [2:0] ACCESS_ACK_D       = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA_D  = 3'd1;

    // Byte-offset width of one full data beat; also the a_size encoding of a full beat.
    function automatic int strb_log2(input int strb_width);
        return $clog2(strb_width);
    endfunction

endpackage

// File: rtl/tl_source_id_pool.sv
// Source-ID pool: tracks in-flight IDs, offers the lowest free ID and counts IDs in use.
module tl_source_id_pool #(
    parameter int SRC_W = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alloc_i,
    input  logic                    free_i,
    input  logic [SRC_W-1:0]        free_id_i,
    output logic [SRC_W-1:0]        alloc_id_o,
    output logic [(1<<SRC_W)-1:0]   inflight_o,
    output logic [SRC_W:0]          count_o,
    output logic                    full_o
);

    localparam int NSRC = 1 << SRC_W;

    logic [NSRC-1:0] inflight_q;
    logic [NSRC-1:0] inflight_d;
    logic [SRC_W:0]  count_q;
    logic [SRC_W:0]  count_d;

    always_comb begin
        alloc_id_o = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (!inflight_q[i]) begin
                alloc_id_o = SRC_W'(i);
            end
        end
    end

    // The allocated ID comes from the pre-edge vector, so it never collides with the ID being freed.
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_slot
        assign inflight_d[gi] = (inflight_q[gi] & ~(free_i && (free_id_i == SRC_W'(gi))))
                              | (alloc_i && (alloc_id_o == SRC_W'(gi)));
    end

    assign count_d = count_q + (SRC_W+1)'(alloc_i) - (SRC_W+1)'(free_i);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= '0;
            count_q    <= '0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
        end
    end

    assign inflight_o = inflight_q;
    assign count_o    = count_q;
    assign full_o     = (count_q == (SRC_W+1)'(NSRC));

endmodule

// File: rtl/tl_ul_master_adapter.sv
// Host-side TL-UL master: turns host read/write requests into A beats and returns D responses in arrival order.
module tl_ul_master_adapter
    import tl_ul_pkg::*;
#(
    parameter int TL_ADDR_WIDTH   = 64,
    parameter int TL_DATA_WIDTH   = 64,
    parameter int TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
    parameter int TL_SOURCE_WIDTH = 3,
    parameter int TL_SINK_WIDTH   = 3,
    parameter int TL_OPCODE_WIDTH = 3,
    parameter int TL_PARAM_WIDTH  = 3,
    parameter int TL_SIZE_WIDTH   = 8
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [TL_ADDR_WIDTH-1:0]    req_addr,
    input  logic [TL_DATA_WIDTH-1:0]    req_wdata,
    input  logic [TL_STRB_WIDTH-1:0]    req_mask,

    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_write,
    output logic [TL_DATA_WIDTH-1:0]    rsp_rdata,
    output logic                        rsp_error,
    output logic [TL_SOURCE_WIDTH-1:0]  rsp_source,

    output logic                        a_valid,
    output logic [TL_OPCODE_WIDTH-1:0]  a_opcode,
    output logic [TL_PARAM_WIDTH-1:0]   a_param,
    output logic [TL_ADDR_WIDTH-1:0]    a_address,
    output logic [TL_SIZE_WIDTH-1:0]    a_size,
    output logic [TL_STRB_WIDTH-1:0]    a_mask,
    output logic [TL_DATA_WIDTH-1:0]    a_data,
    output logic [TL_SOURCE_WIDTH-1:0]  a_source,
    input  logic                        a_ready,

    input  logic                        d_valid,
    input  logic [TL_OPCODE_WIDTH-1:0]  d_opcode,
    input  logic [TL_PARAM_WIDTH-1:0]   d_param,
    input  logic [TL_SIZE_WIDTH-1:0]    d_size,
    input  logic [TL_DATA_WIDTH-1:0]    d_data,
    input  logic [TL_SOURCE_WIDTH-1:0]  d_source,
    input  logic [TL_SINK_WIDTH-1:0]    d_sink,
    input  logic                        d_error,
    output logic                        d_ready,

    output logic [TL_SOURCE_WIDTH:0]    outstanding,
    output logic                        unexpected_rsp
);

    localparam int OFF  = strb_log2(TL_STRB_WIDTH);
    localparam int NSRC = 1 << TL_SOURCE_WIDTH;

    logic                       a_valid_q, a_valid_d;
    logic [TL_OPCODE_WIDTH-1:0] a_opcode_q, a_opcode_d;
    logic [TL_ADDR_WIDTH-1:0]   a_address_q, a_address_d;
    logic [TL_SIZE_WIDTH-1:0]   a_size_q;
    logic [TL_STRB_WIDTH-1:0]   a_mask_q, a_mask_d;
    logic [TL_DATA_WIDTH-1:0]   a_data_q, a_data_d;
    logic [TL_SOURCE_WIDTH-1:0] a_source_q;

    logic                       rsp_valid_q, rsp_valid_d;
    logic                       rsp_write_q;
    logic [TL_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                       rsp_error_q, rsp_error_d;
    logic [TL_SOURCE_WIDTH-1:0] rsp_source_q;

    logic [NSRC-1:0]            is_read_q;
    logic                       unexpected_q;

    logic [TL_SOURCE_WIDTH-1:0] alloc_id;
    logic [NSRC-1:0]            inflight;
    logic                       pool_full;
    logic                       accept;
    logic                       d_hs;
    logic                       d_hit;
    logic                       d_free;
    logic                       src_is_read;
    logic                       unused_inputs;

    assign unused_inputs = ^{d_param, d_size, d_sink, req_addr[OFF-1:0]};

    assign req_ready = (!a_valid_q || a_ready) && !pool_full;
    assign accept    = req_valid && req_ready;

    assign d_ready     = !rsp_valid_q || rsp_ready;
    assign d_hs        = d_valid && d_ready;
    assign d_hit       = inflight[d_source];
    assign d_free      = d_hs && d_hit;
    assign src_is_read = is_read_q[d_source];

    tl_source_id_pool #(
        .SRC_W      (TL_SOURCE_WIDTH)
    ) u_pool (
        .clk        (clk),
        .rst        (rst),
        .alloc_i    (accept),
        .free_i     (d_free),
        .free_id_i  (d_source),
        .alloc_id_o (alloc_id),
        .inflight_o (inflight),
        .count_o    (outstanding),
        .full_o     (pool_full)
    );

    always_comb begin
        a_valid_d   = accept ? 1'b1 : (a_ready ? 1'b0 : a_valid_q);
        a_address_d = {req_addr[TL_ADDR_WIDTH-1:OFF], OFF'(0)};
        a_mask_d    = req_write ? req_mask : '1;
        a_data_d    = req_write ? req_wdata : '0;
        if (!req_write) begin
            a_opcode_d = TL_OPCODE_WIDTH'(GET_A);
        end else if (&req_mask) begin
            a_opcode_d = TL_OPCODE_WIDTH'(PUT_FULL_DATA_A);
        end else begin
            a_opcode_d = TL_OPCODE_WIDTH'(PUT_PARTIAL_DATA_A);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_valid_q   <= 1'b0;
            a_opcode_q  <= '0;
            a_address_q <= '0;
            a_size_q    <= '0;
            a_mask_q    <= '0;
            a_data_q    <= '0;
            a_source_q  <= '0;
            is_read_q   <= '0;
        end else begin
            a_valid_q <= a_valid_d;
            if (accept) begin
                a_opcode_q          <= a_opcode_d;
                a_address_q         <= a_address_d;
                a_size_q            <= TL_SIZE_WIDTH'(OFF);
                a_mask_q            <= a_mask_d;
                a_data_q            <= a_data_d;
                a_source_q          <= alloc_id;
                is_read_q[alloc_id] <= !req_write;
            end
        end
    end

    // A read must be answered with AccessAckData and a write with AccessAck; anything else is an error.
    always_comb begin
        rsp_valid_d = d_free ? 1'b1 : (rsp_ready ? 1'b0 : rsp_valid_q);
        rsp_rdata_d = src_is_read ? d_data : '0;
        rsp_error_d = d_error
                    | (src_is_read  && (d_opcode != TL_OPCODE_WIDTH'(ACCESS_ACK_DATA_D)))
                    | (!src_is_read && (d_opcode != TL_OPCODE_WIDTH'(ACCESS_ACK_D)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_write_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_error_q  <= 1'b0;
            rsp_source_q <= '0;
            unexpected_q <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            if (d_free) begin
                rsp_write_q  <= !src_is_read;
                rsp_rdata_q  <= rsp_rdata_d;
                rsp_error_q  <= rsp_error_d;
                rsp_source_q <= d_source;
            end
            if (d_hs && !d_hit) begin
                unexpected_q <= 1'b1;
            end
        end
    end

    assign a_valid        = a_valid_q;
    assign a_opcode       = a_opcode_q;
    assign a_param        = '0;
    assign a_address      = a_address_q;
    assign a_size         = a_size_q;
    assign a_mask         = a_mask_q;
    assign a_data         = a_data_q;
    assign a_source       = a_source_q;

    assign rsp_valid      = rsp_valid_q;
    assign rsp_write      = rsp_write_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_error      = rsp_error_q;
    assign rsp_source     = rsp_source_q;

    assign unexpected_rsp = unexpected_q;

endmodule

// File: tb/tb_tl_ul_master_adapter.sv
// Directed bench for tl_ul_master_adapter: request encoding, source allocation, out-of-order responses, back-pressure, errors and reset.
module tb_tl_ul_master_adapter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_mask = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_write;
    logic [63:0] rsp_rdata;
    logic        rsp_error;
    logic [2:0]  rsp_source;
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [63:0] a_address;
    logic [7:0]  a_size;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic [2:0]  a_source;
    logic        a_ready = 1'b1;
    logic        d_valid = 1'b0;
    logic [2:0]  d_opcode = '0;
    logic [2:0]  d_param = '0;
    logic [7:0]  d_size = '0;
    logic [63:0] d_data = '0;
    logic [2:0]  d_source = '0;
    logic [2:0]  d_sink = '0;
    logic        d_error = 1'b0;
    logic        d_ready;
    logic [3:0]  outstanding;
    logic        unexpected_rsp;

    int tests = 0;
    int fails = 0;

    tl_ul_master_adapter dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_mask       (req_mask),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_write      (rsp_write),
        .rsp_rdata      (rsp_rdata),
        .rsp_error      (rsp_error),
        .rsp_source     (rsp_source),
        .a_valid        (a_valid),
        .a_opcode       (a_opcode),
        .a_param        (a_param),
        .a_address      (a_address),
        .a_size         (a_size),
        .a_mask         (a_mask),
        .a_data         (a_data),
        .a_source       (a_source),
        .a_ready        (a_ready),
        .d_valid        (d_valid),
        .d_opcode       (d_opcode),
        .d_param        (d_param),
        .d_size         (d_size),
        .d_data         (d_data),
        .d_source       (d_source),
        .d_sink         (d_sink),
        .d_error        (d_error),
        .d_ready        (d_ready),
        .outstanding    (outstanding),
        .unexpected_rsp (unexpected_rsp)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Called at a falling edge; returns at the falling edge right after the accepting rising edge.
    task automatic send(input logic w, input logic [63:0] addr, input logic [63:0] data, input logic [7:0] mask);
        int n;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = addr;
        req_wdata = data;
        req_mask  = mask;
        n = 0;
        #1;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        check("req_ready_wait", {63'd0, req_ready}, 64'd1);
        tick();
        req_valid = 1'b0;
        $display("[TB] req w=%0d addr=%h mask=%h -> a_source=%0d a_opcode=%0d", w, addr, mask, a_source, a_opcode);
    endtask

    task automatic send_d(input logic [2:0] op, input logic [2:0] src, input logic [63:0] data, input logic err);
        int n;
        d_valid  = 1'b1;
        d_opcode = op;
        d_source = src;
        d_data   = data;
        d_error  = err;
        n = 0;
        #1;
        while (!d_ready && n < 20) begin
            tick();
            n++;
        end
        check("d_ready_wait", {63'd0, d_ready}, 64'd1);
        tick();
        d_valid = 1'b0;
        $display("[TB] d op=%0d src=%0d -> rsp_valid=%0d rsp_src=%0d err=%0d", op, src, rsp_valid, rsp_source, rsp_error);
    endtask

    initial begin
        tick();
        check("rst_a_valid", {63'd0, a_valid}, 64'd0);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_outstanding", {60'd0, outstanding}, 64'd0);
        check("rst_unexpected", {63'd0, unexpected_rsp}, 64'd0);
        check("rst_d_ready", {63'd0, d_ready}, 64'd1);
        check("rst_a_address", a_address, 64'd0);
        rst = 1'b1;
        tick();

        // Full write
        send(1'b1, 64'h0, 64'hDEADBEEF_CAFEBABE, 8'hFF);
        check("w_a_valid", {63'd0, a_valid}, 64'd1);
        check("w_a_opcode", {61'd0, a_opcode}, 64'd0);
        check("w_a_source", {61'd0, a_source}, 64'd0);
        check("w_a_size", {56'd0, a_size}, 64'd3);
        check("w_a_data", a_data, 64'hDEADBEEF_CAFEBABE);
        check("w_a_mask", {56'd0, a_mask}, 64'hFF);
        check("w_a_param", {61'd0, a_param}, 64'd0);
        check("w_outstanding", {60'd0, outstanding}, 64'd1);
        tick();
        check("w_a_valid_drop", {63'd0, a_valid}, 64'd0);
        send_d(3'd0, 3'd0, 64'h0, 1'b0);
        check("w_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("w_rsp_write", {63'd0, rsp_write}, 64'd1);
        check("w_rsp_error", {63'd0, rsp_error}, 64'd0);
        check("w_rsp_source", {61'd0, rsp_source}, 64'd0);
        check("w_rsp_rdata", rsp_rdata, 64'd0);
        check("w_outstanding0", {60'd0, outstanding}, 64'd0);
        tick();
        check("w_rsp_valid_drop", {63'd0, rsp_valid}, 64'd0);

        // Two back-to-back reads answered out of order
        send(1'b0, 64'h600, 64'h1234, 8'h00);
        check("r0_a_source", {61'd0, a_source}, 64'd0);
        check("r0_a_opcode", {61'd0, a_opcode}, 64'd4);
        check("r0_a_mask", {56'd0, a_mask}, 64'hFF);
        check("r0_a_data", a_data, 64'd0);
        check("r0_a_address", a_address, 64'h600);
        send(1'b0, 64'h1200, 64'h0, 8'h00);
        check("r1_a_valid", {63'd0, a_valid}, 64'd1);
        check("r1_a_source", {61'd0, a_source}, 64'd1);
        check("r1_a_address", a_address, 64'h1200);
        check("r_outstanding2", {60'd0, outstanding}, 64'd2);
        send_d(3'd1, 3'd1, 64'h1111_2222_3333_4444, 1'b0);
        check("r1_rsp_source", {61'd0, rsp_source}, 64'd1);
        check("r1_rsp_rdata", rsp_rdata, 64'h1111_2222_3333_4444);
        check("r1_rsp_write", {63'd0, rsp_write}, 64'd0);
        check("r1_rsp_error", {63'd0, rsp_error}, 64'd0);
        check("r_outstanding1", {60'd0, outstanding}, 64'd1);
        send_d(3'd1, 3'd0, 64'h5555_6666_7777_8888, 1'b0);
        check("r0_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("r0_rsp_source", {61'd0, rsp_source}, 64'd0);
        check("r0_rsp_rdata", rsp_rdata, 64'h5555_6666_7777_8888);
        check("r_outstanding0", {60'd0, outstanding}, 64'd0);

        // Exhaust the pool
        for (int i = 0; i < 8; i++) begin
            send(1'b0, 64'(i * 8), 64'h0, 8'h00);
            check("fill_a_source", {61'd0, a_source}, 64'(i));
        end
        check("full_outstanding", {60'd0, outstanding}, 64'd8);
        check("full_req_ready", {63'd0, req_ready}, 64'd0);
        tick();
        check("full_req_ready_hold", {63'd0, req_ready}, 64'd0);
        send_d(3'd1, 3'd5, 64'hA5, 1'b0);
        check("free5_rsp_source", {61'd0, rsp_source}, 64'd5);
        check("free5_outstanding", {60'd0, outstanding}, 64'd7);
        check("free5_req_ready", {63'd0, req_ready}, 64'd1);
        send(1'b0, 64'h100, 64'h0, 8'h00);
        check("realloc_a_source", {61'd0, a_source}, 64'd5);
        check("realloc_outstanding", {60'd0, outstanding}, 64'd8);
        for (int i = 0; i < 8; i++) begin
            send_d(3'd1, 3'(i), 64'(i + 16), 1'b0);
            check("drain_rsp_source", {61'd0, rsp_source}, 64'(i));
            check("drain_rsp_rdata", rsp_rdata, 64'(i + 16));
        end
        check("drain_outstanding", {60'd0, outstanding}, 64'd0);

        // Partial writes
        send(1'b1, 64'h203, 64'h0102_0304_0506_0708, 8'h0F);
        check("pw_a_opcode", {61'd0, a_opcode}, 64'd1);
        check("pw_a_address", a_address, 64'h200);
        check("pw_a_mask", {56'd0, a_mask}, 64'h0F);
        check("pw_a_data", a_data, 64'h0102_0304_0506_0708);
        send(1'b1, 64'h300, 64'h9, 8'h00);
        check("pw0_a_opcode", {61'd0, a_opcode}, 64'd1);
        check("pw0_a_mask", {56'd0, a_mask}, 64'h00);
        check("pw0_a_source", {61'd0, a_source}, 64'd1);
        send_d(3'd0, 3'd0, 64'hFFFF, 1'b0);
        check("pw_rsp_rdata", rsp_rdata, 64'd0);
        check("pw_rsp_error", {63'd0, rsp_error}, 64'd0);
        send_d(3'd0, 3'd1, 64'h0, 1'b0);
        check("pw0_rsp_source", {61'd0, rsp_source}, 64'd1);
        tick();

        // A-channel stall
        a_ready = 1'b0;
        send(1'b0, 64'h40, 64'h0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            check("stall_a_valid", {63'd0, a_valid}, 64'd1);
            check("stall_a_address", a_address, 64'h40);
            check("stall_a_opcode", {61'd0, a_opcode}, 64'd4);
            check("stall_req_ready", {63'd0, req_ready}, 64'd0);
            tick();
        end
        a_ready = 1'b1;
        tick();
        check("stall_a_valid_drop", {63'd0, a_valid}, 64'd0);

        // Response stall
        rsp_ready = 1'b0;
        send_d(3'd1, 3'd0, 64'h77, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("rstall_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            check("rstall_d_ready", {63'd0, d_ready}, 64'd0);
            check("rstall_rsp_rdata", rsp_rdata, 64'h77);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("rstall_d_ready_back", {63'd0, d_ready}, 64'd1);
        tick();
        check("rstall_rsp_valid_drop", {63'd0, rsp_valid}, 64'd0);

        // Error responses
        send(1'b0, 64'h80, 64'h0, 8'h00);
        send_d(3'd0, 3'd0, 64'h55, 1'b0);
        check("err_op_rsp_error", {63'd0, rsp_error}, 64'd1);
        check("err_op_rsp_rdata", rsp_rdata, 64'h55);
        send(1'b1, 64'h88, 64'h1, 8'hFF);
        send_d(3'd0, 3'd0, 64'h0, 1'b1);
        check("err_d_rsp_error", {63'd0, rsp_error}, 64'd1);
        check("err_d_rsp_write", {63'd0, rsp_write}, 64'd1);
        send_d(3'd1, 3'd7, 64'h99, 1'b0);
        check("unexp_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("unexp_flag", {63'd0, unexpected_rsp}, 64'd1);
        check("unexp_outstanding", {60'd0, outstanding}, 64'd0);
        tick();
        check("unexp_sticky", {63'd0, unexpected_rsp}, 64'd1);

        // Reset with three requests in flight and one A beat stalled
        send(1'b0, 64'h10, 64'h0, 8'h00);
        send(1'b0, 64'h18, 64'h0, 8'h00);
        send(1'b0, 64'h20, 64'h0, 8'h00);
        a_ready = 1'b0;
        tick();
        check("pre_rst_outstanding", {60'd0, outstanding}, 64'd3);
        check("pre_rst_a_valid", {63'd0, a_valid}, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_outstanding", {60'd0, outstanding}, 64'd0);
        check("mid_rst_a_valid", {63'd0, a_valid}, 64'd0);
        check("mid_rst_unexpected", {63'd0, unexpected_rsp}, 64'd0);
        tick();
        rst = 1'b1;
        a_ready = 1'b1;
        send_d(3'd1, 3'd1, 64'h42, 1'b0);
        check("post_rst_unexpected", {63'd0, unexpected_rsp}, 64'd1);
        check("post_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
